// File: rtl/vga_display_controller_pkg.sv
// vga_display_controller_pkg: command codes and controller state encodings shared with the command decoder
package vga_display_controller_pkg;
  typedef enum logic [2:0] {
    VGA_NOP          = 3'd0,
    VGA_PREPARE      = 3'd1,
    VGA_STOP         = 3'd2,
    VGA_TEST_PATTERN = 3'd3
  } vga_cmd_e;
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START_FIFO = 3'd1,
    ST_PRIME      = 3'd2,
    ST_DISPLAY    = 3'd3,
    ST_STOPPING   = 3'd4,
    ST_TEST       = 3'd5
  } vga_state_e;
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running raster counters with pre-register active, sync and frame-boundary flags
module vga_timing #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FRONT   = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BACK    = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FRONT   = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BACK    = 33,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  localparam int  H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int  HW        = $clog2(H_TOTAL),
  localparam int  VW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          frame
);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last;
  assign h_last = int'(h_q) == H_TOTAL - 1;
  // advance the raster position, wrapping at end of line and end of frame
  always_comb begin
    h_d = h_last ? '0 : h_q + 1'b1;
    v_d = !h_last ? v_q : (int'(v_q) == V_TOTAL - 1) ? '0 : v_q + 1'b1;
  end
  // position registers run in every controller state so the monitor stays locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end
  assign h      = h_q;
  assign v      = v_q;
  assign active = int'(h_q) < H_ACTIVE && int'(v_q) < V_ACTIVE;
  assign hsync  = (int'(h_q) >= H_ACTIVE + H_FRONT && int'(h_q) < H_ACTIVE + H_FRONT + H_SYNC) ? HSYNC_POL : !HSYNC_POL;
  assign vsync  = (int'(v_q) >= V_ACTIVE + V_FRONT && int'(v_q) < V_ACTIVE + V_FRONT + V_SYNC) ? VSYNC_POL : !VSYNC_POL;
  assign frame  = h_q == '0 && v_q == '0;
endmodule

// File: rtl/vga_display_controller.sv
// vga_display_controller: command-driven VGA streamer from a show-ahead FIFO; VGA_TEST_PATTERN_EN adds a colour-bar TEST state
module vga_display_controller
  import vga_display_controller_pkg::*;
#(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter int   COLOR_WIDTH = 12,
  parameter logic HSYNC_POL   = 1'b0,
  parameter logic VSYNC_POL   = 1'b0,
  parameter logic [COLOR_WIDTH-1:0] UNDERFLOW_COLOR = '1,
  localparam int  H_TOTAL     = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int  V_TOTAL     = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int  HW          = $clog2(H_TOTAL),
  localparam int  VW          = $clog2(V_TOTAL)
) (
  input  logic                   vga_clock,
  input  logic                   reset_n,
  input  logic [2:0]             command,
  output logic                   clear_command,
  output logic                   enable_vga_fifo,
  input  logic [COLOR_WIDTH-1:0] vga_data,
  input  logic                   fifo_empty,
  output logic                   fifo_read,
  output logic                   hsync,
  output logic                   vsync,
  output logic [COLOR_WIDTH-1:0] rgb,
  output logic                   frame_start,
  output logic                   underflow
);
  logic [HW-1:0]          h;
  logic [VW-1:0]          v;
  logic                   active, hs, vs, frame, eof, prime_go;
  vga_state_e             state_q, state_d;
  logic                   clear_q, clear_d, en_q, en_d, uf_q, uf_d;
  logic [COLOR_WIDTH-1:0] rgb_q, rgb_d;
  logic                   hs_q, vs_q, fs_q;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .clk(vga_clock), .rst_n(reset_n), .h(h), .v(v),
    .active(active), .hsync(hs), .vsync(vs), .frame(frame)
  );
  assign eof = int'(h) == H_TOTAL - 1 && int'(v) == V_TOTAL - 1;
  // leaving PRIME pops on the boundary pixel itself so the first word lands on pixel 0
  assign prime_go  = state_q == ST_PRIME && command != VGA_STOP && frame && !fifo_empty;
  assign fifo_read = active && (state_q == ST_DISPLAY || state_q == ST_STOPPING || prime_go);
`ifdef VGA_TEST_PATTERN_EN
  localparam int CW = COLOR_WIDTH / 3;
  logic [2:0] bar;
  assign bar = 3'(int'(h) / (H_ACTIVE / 8));
`endif
  // command handling and state sequencing; clear_command and the fifo enable move with the transition
  always_comb begin
    state_d = state_q;
    clear_d = 1'b0;
    en_d    = en_q;
    uf_d    = uf_q | (fifo_read & fifo_empty);
    case (state_q)
      ST_IDLE:
        if (command == VGA_PREPARE) begin
          state_d = ST_START_FIFO;
          clear_d = 1'b1;
          en_d    = 1'b1;
          uf_d    = 1'b0;
        end
`ifdef VGA_TEST_PATTERN_EN
        else if (command == VGA_TEST_PATTERN) begin
          state_d = ST_TEST;
          clear_d = 1'b1;
        end
`endif
      ST_START_FIFO: state_d = ST_PRIME;
      ST_PRIME:
        if (command == VGA_STOP) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
          en_d    = 1'b0;
        end else if (prime_go) state_d = ST_DISPLAY;
      ST_DISPLAY:
        if (command == VGA_STOP) begin
          state_d = ST_STOPPING;
          clear_d = 1'b1;
          en_d    = 1'b0;
        end
      ST_STOPPING:
        if (eof) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
        end
`ifdef VGA_TEST_PATTERN_EN
      ST_TEST:
        if (command == VGA_STOP && eof) begin
          state_d = ST_IDLE;
          clear_d = 1'b1;
        end
`endif
      default: state_d = ST_IDLE;
    endcase
  end
  // pixel source: FIFO head (or the underflow colour) while popping, colour bars in TEST, black otherwise
  always_comb begin
    rgb_d = fifo_read ? (fifo_empty ? UNDERFLOW_COLOR : vga_data) : '0;
`ifdef VGA_TEST_PATTERN_EN
    if (state_q == ST_TEST && active) rgb_d = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
`endif
  end
  // one uniform register stage for state, pixel, syncs and frame pulse
  always_ff @(posedge vga_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      clear_q <= 1'b0;
      en_q    <= 1'b0;
      uf_q    <= 1'b0;
      rgb_q   <= '0;
      hs_q    <= !HSYNC_POL;
      vs_q    <= !VSYNC_POL;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_d;
      en_q    <= en_d;
      uf_q    <= uf_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs;
      vs_q    <= vs;
      fs_q    <= frame;
    end
  end
  assign clear_command   = clear_q;
  assign enable_vga_fifo = en_q;
  assign underflow       = uf_q;
  assign rgb             = rgb_q;
  assign hsync           = hs_q;
  assign vsync           = vs_q;
  assign frame_start     = fs_q;
endmodule

// File: tb/tb_vga_display_controller.sv
// tb_vga_display_controller: directed checks of timing, streaming, underflow, stop, reset and command filtering on a 14x7 raster
module tb_vga_display_controller;
  import vga_display_controller_pkg::*;
  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  command = VGA_NOP;
  logic        clear_command, enable_vga_fifo, fifo_empty, fifo_read;
  logic        hsync, vsync, frame_start, underflow;
  logic [11:0] vga_data, rgb;
  logic [11:0] q[$];
  int          n, errs, checks, pops;
  vga_display_controller #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .COLOR_WIDTH(12)
  ) dut (
    .vga_clock(clk), .reset_n(rst_n), .command(command), .clear_command(clear_command),
    .enable_vga_fifo(enable_vga_fifo), .vga_data(vga_data), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .frame_start(frame_start), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask
  task automatic refresh();
    fifo_empty = q.size() == 0;
    vga_data   = fifo_empty ? 12'h0 : q[0];
  endtask
  task automatic step();
    logic rd;
    @(negedge clk);
    rd = fifo_read;
    @(posedge clk);
    #1;
    n++;
    if (rd && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
    refresh();
  endtask
  task automatic chk_reset(input string tag);
    check({tag, "_hs"}, 32'(hsync), 1);
    check({tag, "_vs"}, 32'(vsync), 1);
    check({tag, "_rgb"}, 32'(rgb), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_clr"}, 32'(clear_command), 0);
    check({tag, "_en"}, 32'(enable_vga_fifo), 0);
    check({tag, "_rd"}, 32'(fifo_read), 0);
    check({tag, "_uf"}, 32'(underflow), 0);
  endtask
  task automatic prepare(input int words, input logic [11:0] base);
    for (int i = 0; i < words; i++) q.push_back(base + 12'(i));
    refresh();
    command = VGA_PREPARE;
    step();
    check("prep_clr", 32'(clear_command), 1);
    check("prep_en", 32'(enable_vga_fifo), 1);
    command = VGA_NOP;
    step();
    check("prep_clr_drop", 32'(clear_command), 0);
    check("prep_uf_clr", 32'(underflow), 0);
    while (n % FT != 0) step();
  endtask
  function automatic logic [31:0] hs_exp(input int c);
    return (c % HT == 10 || c % HT == 11) ? 0 : 1;
  endfunction
  function automatic logic [31:0] vs_exp(input int c);
    return ((c / HT) % VT == 5) ? 0 : 1;
  endfunction
  function automatic logic [31:0] pix_exp(input int k);
    int h = k % HT;
    int v = k / HT;
    return (h < 8 && v < 4) ? 32'(v * 8 + h + 1) : 0;
  endfunction
  function automatic logic [31:0] bar_exp(input int k);
    logic [2:0] b = 3'(k);
    return k < 8 ? 32'({{4{b[2]}}, {4{b[1]}}, {4{b[0]}}}) : 0;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    refresh();
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      check("hsync", 32'(hsync), hs_exp(n - 1));
      check("vsync", 32'(vsync), vs_exp(n - 1));
      check("frame_start", 32'(frame_start), (n - 1) % FT == 0 ? 1 : 0);
      check("idle_rd", 32'(fifo_read), 0);
      check("idle_rgb", 32'(rgb), 0);
    end
    prepare(32, 12'h001);
    check("prime_rd", 32'(fifo_read), 1);
    for (int k = 0; k < FT; k++) begin
      if (k == 18) command = VGA_STOP;
      step();
      if (k == 18) begin
        check("stop_clr", 32'(clear_command), 1);
        check("stop_en", 32'(enable_vga_fifo), 0);
        command = VGA_NOP;
      end
      check("pix", 32'(rgb), pix_exp(k));
    end
    check("stream_pops", 32'(pops), 32);
    check("stream_uf", 32'(underflow), 0);
    for (int i = 0; i < HT; i++) begin
      check("after_stop_rd", 32'(fifo_read), 0);
      step();
    end
    prepare(5, 12'hA01);
    for (int k = 0; k < HT; k++) begin
      step();
      check("uf_pix", 32'(rgb), k < 5 ? 32'(12'hA01 + 12'(k)) : k < 8 ? 32'hFFF : 0);
      if (k == 4) check("uf_early", 32'(underflow), 0);
    end
    check("uf_set", 32'(underflow), 1);
    command = VGA_STOP;
    step();
    check("uf_stop_clr", 32'(clear_command), 1);
    command = VGA_NOP;
    while (n % FT != 0) step();
    check("uf_idle_rd", 32'(fifo_read), 0);
    check("uf_sticky", 32'(underflow), 1);
    prepare(0, 12'h000);
    for (int i = 0; i < FT; i++) begin
      check("prime_wait_rd", 32'(fifo_read), 0);
      step();
      check("prime_wait_rgb", 32'(rgb), 0);
    end
    command = VGA_STOP;
    step();
    check("prime_stop_clr", 32'(clear_command), 1);
    check("prime_stop_en", 32'(enable_vga_fifo), 0);
    command = VGA_NOP;
    q.push_back(12'h555);
    refresh();
    while (n % FT != 0) step();
    check("prime_stop_rd", 32'(fifo_read), 0);
    q.delete();
    refresh();
    prepare(2, 12'hB01);
    repeat (20) step();
    check("pre_rst_uf", 32'(underflow), 1);
    check("pre_rst_rd", 32'(fifo_read), 1);
    check("pre_rst_rgb", 32'(rgb), 32'hFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    q.delete();
    refresh();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    step();
    check("rst_fs", 32'(frame_start), 1);
    step();
    check("rst_fs_drop", 32'(frame_start), 0);
    check("rst_rd", 32'(fifo_read), 0);
`ifdef VGA_TEST_PATTERN_EN
    command = VGA_TEST_PATTERN;
    step();
    check("tp_clr", 32'(clear_command), 1);
    command = VGA_NOP;
    while (n % FT != 0) step();
    for (int k = 0; k < HT; k++) begin
      step();
      check("tp_pix", 32'(rgb), bar_exp(k));
      check("tp_rd", 32'(fifo_read), 0);
    end
    command = VGA_STOP;
    for (int i = 0; i < 2 * FT && !clear_command; i++) step();
    check("tp_stop_clr", 32'(clear_command), 1);
    check("tp_stop_eof", 32'(n % FT), 0);
    command = VGA_NOP;
    step();
    check("tp_idle_rgb", 32'(rgb), 0);
`else
    command = VGA_TEST_PATTERN;
    for (int i = 0; i < 3; i++) begin
      step();
      check("tp_ignored_clr", 32'(clear_command), 0);
      check("tp_ignored_en", 32'(enable_vga_fifo), 0);
    end
    while (n % FT != 1) step();
    check("tp_ignored_rgb", 32'(rgb), 0);
    command = VGA_NOP;
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
